// File: rtl/barshift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Build option BARSHIFT_STICKY_EN adds the discarded-bit sticky output.
package barshift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } mode_e;

    // Register stages needed for log2(width) mux layers grouped lps per stage.
    function automatic int num_stages(input int width, input int lps);
        return ($clog2(width) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/barshift_layer.sv
// One mux layer: shift/rotate by SHIFT when en is set, else pass through.
// Latency 0 (combinational); no flow control of its own.
// lost_or exists only with BARSHIFT_STICKY_EN: OR of bits pushed past the word edge.
module barshift_layer
    import barshift_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             en,
    input  mode_e            mode,
    input  logic             fill,
`ifdef BARSHIFT_STICKY_EN
    output logic             lost_or,
`endif
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        out_data = in_data;
`ifdef BARSHIFT_STICKY_EN
        lost_or  = 1'b0;
`endif
        if (en) begin
            case (mode)
                SLL:     out_data = {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
                SRL:     out_data = {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]};
                SRA:     out_data = {{SHIFT{fill}}, in_data[WIDTH-1:SHIFT]};
                default: out_data = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
            endcase
`ifdef BARSHIFT_STICKY_EN
            // SRA drops low bits just like SRL; rotation never loses anything
            if (mode == SLL) begin
                lost_or = |in_data[WIDTH-1 -: SHIFT];
            end else if (mode != ROR) begin
                lost_or = |in_data[SHIFT-1:0];
            end
`endif
        end
    end

endmodule

// File: rtl/barshift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter, LPS mux layers per register stage.
// Latency ceil(log2(WIDTH)/LPS) cycles, 1 beat/cycle; global stall: in_ready = out_ready | ~out_valid.
// Option BARSHIFT_STICKY_EN adds out_sticky (OR of discarded bits), pipelined with the data.
module barshift_pipe
    import barshift_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int LPS   = 2,
    parameter int TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
`ifdef BARSHIFT_STICKY_EN
    ,
    output logic                     out_sticky
`endif
);

    localparam int SHW = $clog2(WIDTH);
    localparam int NS  = num_stages(WIDTH, LPS);

    logic             vld_q  [NS];
    logic             vld_d  [NS];
    logic [WIDTH-1:0] dat_q  [NS];
    logic [WIDTH-1:0] dat_d  [NS];
    logic [SHW-1:0]   amt_q  [NS];
    logic [SHW-1:0]   amt_d  [NS];
    mode_e            mode_q [NS];
    mode_e            mode_d [NS];
    logic             fill_q [NS];
    logic             fill_d [NS];
    logic [TAG_W-1:0] tag_q  [NS];
    logic [TAG_W-1:0] tag_d  [NS];

    logic             src_vld  [NS];
    logic [WIDTH-1:0] src_dat  [NS];
    logic [SHW-1:0]   src_amt  [NS];
    mode_e            src_mode [NS];
    logic             src_fill [NS];
    logic [TAG_W-1:0] src_tag  [NS];

    logic [WIDTH-1:0] lyr_in   [SHW];
    logic [WIDTH-1:0] lyr_out  [SHW];
    logic [WIDTH-1:0] stg_out  [NS];

`ifdef BARSHIFT_STICKY_EN
    logic             stk_q    [NS];
    logic             stk_d    [NS];
    logic             src_stk  [NS];
    logic             lyr_lost [SHW];
    logic             lyr_stk  [SHW];
    logic             stg_stk  [NS];
`endif

    logic adv;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Stage 0 is fed by the ports, every later stage by its predecessor's registers.
    always_comb begin
        src_vld[0]  = in_valid & in_ready;
        src_dat[0]  = in_data;
        src_amt[0]  = in_amt;
        src_mode[0] = mode_e'(in_mode);
        src_fill[0] = in_data[WIDTH-1];
        src_tag[0]  = in_tag;
`ifdef BARSHIFT_STICKY_EN
        src_stk[0]  = 1'b0;
`endif
        for (int s = 1; s < NS; s++) begin
            src_vld[s]  = vld_q[s-1];
            src_dat[s]  = dat_q[s-1];
            src_amt[s]  = amt_q[s-1];
            src_mode[s] = mode_q[s-1];
            src_fill[s] = fill_q[s-1];
            src_tag[s]  = tag_q[s-1];
`ifdef BARSHIFT_STICKY_EN
            src_stk[s]  = stk_q[s-1];
`endif
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_lyr
        localparam int S = k / LPS;

        if (k % LPS == 0) begin : g_head
            assign lyr_in[k] = src_dat[S];
`ifdef BARSHIFT_STICKY_EN
            assign lyr_stk[k] = src_stk[S] | lyr_lost[k];
`endif
        end else begin : g_chain
            assign lyr_in[k] = lyr_out[k-1];
`ifdef BARSHIFT_STICKY_EN
            assign lyr_stk[k] = lyr_stk[k-1] | lyr_lost[k];
`endif
        end

        barshift_layer #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_layer (
            .in_data  (lyr_in[k]),
            .en       (src_amt[S][k]),
            .mode     (src_mode[S]),
            .fill     (src_fill[S]),
`ifdef BARSHIFT_STICKY_EN
            .lost_or  (lyr_lost[k]),
`endif
            .out_data (lyr_out[k])
        );

        // The last layer of each group feeds that group's stage register.
        if (((k + 1) % LPS == 0) || (k == SHW - 1)) begin : g_tap
            assign stg_out[S] = lyr_out[k];
`ifdef BARSHIFT_STICKY_EN
            assign stg_stk[S] = lyr_stk[k];
`endif
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            vld_d[s]  = src_vld[s];
            dat_d[s]  = stg_out[s];
            amt_d[s]  = src_amt[s];
            mode_d[s] = src_mode[s];
            fill_d[s] = src_fill[s];
            tag_d[s]  = src_tag[s];
`ifdef BARSHIFT_STICKY_EN
            stk_d[s]  = stg_stk[s];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                vld_q[s]  <= 1'b0;
                dat_q[s]  <= '0;
                amt_q[s]  <= '0;
                mode_q[s] <= SLL;
                fill_q[s] <= 1'b0;
                tag_q[s]  <= '0;
`ifdef BARSHIFT_STICKY_EN
                stk_q[s]  <= 1'b0;
`endif
            end
        end else if (adv) begin
            for (int s = 0; s < NS; s++) begin
                vld_q[s]  <= vld_d[s];
                dat_q[s]  <= dat_d[s];
                amt_q[s]  <= amt_d[s];
                mode_q[s] <= mode_d[s];
                fill_q[s] <= fill_d[s];
                tag_q[s]  <= tag_d[s];
`ifdef BARSHIFT_STICKY_EN
                stk_q[s]  <= stk_d[s];
`endif
            end
        end
    end

    assign out_valid  = vld_q[NS-1];
    assign out_data   = dat_q[NS-1];
    assign out_tag    = tag_q[NS-1];
`ifdef BARSHIFT_STICKY_EN
    assign out_sticky = stk_q[NS-1];
`endif

endmodule

// File: tb/tb_barshift_pipe.sv
// Bench for barshift_pipe: 128b/LPS=2 instance with scoreboard, plus 8b/LPS=1 instance for directed vectors.
// Sticky checks are compiled in only with BARSHIFT_STICKY_EN.
module tb_barshift_pipe;
    import barshift_pkg::*;

    localparam logic [127:0] ONE  = 128'h1;
    localparam logic [127:0] MSB  = {1'b1, 127'b0};
    localparam logic [127:0] ALL1 = {128{1'b1}};
    localparam logic [127:0] PAT  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [6:0]   in_amt = '0;
    logic [1:0]   in_mode = '0;
    logic [7:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [7:0]   out_tag;
    logic         out_sticky;

    logic         r8_vld = 1'b0;
    logic         r8_rdy;
    logic [7:0]   r8_dat = '0;
    logic [2:0]   r8_amt = '0;
    logic [1:0]   r8_mode = '0;
    logic [7:0]   r8_tag = '0;
    logic         o8_vld;
    logic [7:0]   o8_dat;
    logic [7:0]   o8_tag;
    logic         o8_stk;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   tag;
        logic         stk;
    } exp_t;

    typedef struct {
        logic [127:0] data;
        logic [6:0]   amt;
        mode_e        mode;
        logic [127:0] exp;
        logic         stk;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        mode_e      mode;
        logic [7:0] exp;
        logic       stk;
    } vec8_t;

    exp_t  exp_q[$];
    int    pop_log[$];
    exp_t  mon_e;
    vec_t  tv[14];
    vec8_t tv8[11];

    int n_cmp = 0;
    int n_bad = 0;
    int n_push = 0;
    int n_pop = 0;
    int cyc = 0;
    bit rand_bp = 1'b0;

    barshift_pipe #(.WIDTH(128), .LPS(2), .TAG_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag)
`ifdef BARSHIFT_STICKY_EN
        , .out_sticky(out_sticky)
`endif
    );

    barshift_pipe #(.WIDTH(8), .LPS(1), .TAG_W(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(r8_vld), .in_ready(r8_rdy), .in_data(r8_dat),
        .in_amt(r8_amt), .in_mode(r8_mode), .in_tag(r8_tag),
        .out_valid(o8_vld), .out_ready(1'b1), .out_data(o8_dat),
        .out_tag(o8_tag)
`ifdef BARSHIFT_STICKY_EN
        , .out_sticky(o8_stk)
`endif
    );

`ifndef BARSHIFT_STICKY_EN
    assign out_sticky = 1'b0;
    assign o8_stk     = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-word shifts; sticky from explicit masks of the dropped bits.
    function automatic logic [128:0] model(input logic [127:0] d, input logic [6:0] a, input mode_e m);
        logic [127:0] r;
        logic         s;
        logic [127:0] low_mask;
        logic [127:0] high_mask;
        low_mask  = ~(ALL1 << a);
        high_mask = ~(ALL1 >> a);
        r = d;
        s = 1'b0;
        case (m)
            SLL: begin r = d << a; s = |(d & high_mask); end
            SRL: begin r = d >> a; s = |(d & low_mask); end
            SRA: begin r = 128'($signed(d) >>> a); s = |(d & low_mask); end
            default: if (a != 0) r = (d >> a) | (d << (128 - int'(a)));
        endcase
        return {s, r};
    endfunction

    // Present a beat from posedge+1 and hold it until accepted; queue its expectation.
    task automatic send(input logic [127:0] d, input logic [6:0] a, input mode_e m,
                        input logic [7:0] t, input logic [127:0] ed, input logic es);
        exp_t e;
        bit   acc;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_tag   = t;
        acc = 1'b0;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check("accept", 128'(acc), 128'd1);
        if (acc) begin
            e.data = ed;
            e.tag  = t;
            e.stk  = es;
            exp_q.push_back(e);
            n_push++;
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run8(input int idx);
        int n;
        r8_vld  = 1'b1;
        r8_dat  = tv8[idx].data;
        r8_amt  = tv8[idx].amt;
        r8_mode = tv8[idx].mode;
        r8_tag  = 8'(idx);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            r8_vld = 1'b0;
        end while (!o8_vld && n < 20);
        check($sformatf("w8_lat_%0d", idx), 128'(n), 128'd3);
        check($sformatf("w8_data_%0d", idx), 128'(o8_dat), 128'(tv8[idx].exp));
        check($sformatf("w8_tag_%0d", idx), 128'(o8_tag), 128'(idx));
`ifdef BARSHIFT_STICKY_EN
        check($sformatf("w8_sticky_%0d", idx), 128'(o8_stk), 128'(tv8[idx].stk));
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got tag %0d data %h, expected no beat", out_tag, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("pop_data_tag%0d", mon_e.tag), out_data, mon_e.data);
                check("pop_tag", 128'(out_tag), 128'(mon_e.tag));
`ifdef BARSHIFT_STICKY_EN
                check($sformatf("pop_sticky_tag%0d", mon_e.tag), 128'(out_sticky), 128'(mon_e.stk));
`endif
                n_pop++;
                pop_log.push_back(cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [128:0] m;
        int pres0;
        int p0;

        tv[0]  = '{ONE,  7'd127, SLL, MSB,  1'b0};
        tv[1]  = '{MSB,  7'd127, SRA, ALL1, 1'b0};
        tv[2]  = '{PAT,  7'd0,   SLL, PAT,  1'b0};
        tv[3]  = '{PAT,  7'd0,   SRL, PAT,  1'b0};
        tv[4]  = '{PAT,  7'd0,   SRA, PAT,  1'b0};
        tv[5]  = '{PAT,  7'd0,   ROR, PAT,  1'b0};
        tv[6]  = '{MSB,  7'd127, SRL, ONE,  1'b0};
        tv[7]  = '{ALL1, 7'd127, SLL, MSB,  1'b1};
        tv[8]  = '{MSB | ONE, 7'd127, ROR, 128'h3, 1'b0};
        tv[9]  = '{ONE,  7'd4,   ROR, {4'h1, 124'b0}, 1'b0};
        tv[10] = '{{8'hff, 120'b0}, 7'd8, SRL, {8'h00, 8'hff, 112'b0}, 1'b0};
        tv[11] = '{MSB,  7'd4,   SRA, {5'b11111, 123'b0}, 1'b0};
        tv[12] = '{PAT,  7'd64,  SLL, 128'hfedc_ba98_7654_3210_0000_0000_0000_0000, 1'b1};
        tv[13] = '{ONE,  7'd1,   SRA, 128'h0, 1'b1};

        tv8[0]  = '{8'hB4, 3'd3, SLL, 8'hA0, 1'b1};
        tv8[1]  = '{8'hB4, 3'd3, SRL, 8'h16, 1'b1};
        tv8[2]  = '{8'hB4, 3'd3, SRA, 8'hF6, 1'b1};
        tv8[3]  = '{8'hB4, 3'd3, ROR, 8'h96, 1'b0};
        tv8[4]  = '{8'h01, 3'd1, SRL, 8'h00, 1'b1};
        tv8[5]  = '{8'h80, 3'd1, SLL, 8'h00, 1'b1};
        tv8[6]  = '{8'hF0, 3'd4, SRL, 8'h0F, 1'b0};
        tv8[7]  = '{8'h5A, 3'd5, ROR, 8'hD2, 1'b0};
        tv8[8]  = '{8'hB4, 3'd7, ROR, 8'h69, 1'b0};
        tv8[9]  = '{8'hB4, 3'd7, SRA, 8'hFF, 1'b1};
        tv8[10] = '{8'hB4, 3'd0, SRA, 8'hB4, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_tag", 128'(out_tag), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < 14; i++) send(tv[i].data, tv[i].amt, tv[i].mode, 8'(i), tv[i].exp, tv[i].stk);
        in_valid = 1'b0;
        drain();

        // back-to-back stream of 16 beats
        pop_log.delete();
        pres0 = cyc;
        for (int i = 0; i < 16; i++) begin
            m = model(PAT ^ 128'(i * 7919), 7'(i * 9), mode_e'(i % 4));
            send(PAT ^ 128'(i * 7919), 7'(i * 9), mode_e'(i % 4), 8'(i), m[127:0], m[128]);
        end
        in_valid = 1'b0;
        drain();
        check("stream_pops", 128'(pop_log.size()), 128'd16);
        if (pop_log.size() == 16) begin
            check("stream_latency", 128'(pop_log[0] - pres0), 128'd4);
            check("stream_consecutive", 128'(pop_log[15] - pop_log[0]), 128'd15);
        end

        // backpressure with a full pipeline
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m = model(~PAT >> i, 7'(3 + 20 * i), mode_e'(i));
            send(~PAT >> i, 7'(3 + 20 * i), mode_e'(i), 8'(32 + i), m[127:0], m[128]);
        end
        m = model(PAT, 7'd33, SRA);
        in_valid = 1'b1;
        in_data  = PAT;
        in_amt   = 7'd33;
        in_mode  = SRA;
        in_tag   = 8'd36;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_hold_data", out_data, exp_q[0].data);
            check("bp_hold_tag", 128'(out_tag), 128'(exp_q[0].tag));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(PAT, 7'd33, SRA, 8'd36, m[127:0], m[128]);
        in_valid = 1'b0;
        drain();
        check("bp_no_loss", 128'(n_pop), 128'(n_push));

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) send(ALL1, 7'(i + 1), SRL, 8'(40 + i), ALL1 >> (i + 1), 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("flush_out_valid", 128'(out_valid), 128'd0);
        check("flush_out_data", out_data, 128'd0);
        rst = 1'b0;
        exp_q.delete();
        n_push -= 3;
        p0 = n_pop;
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_stale", 128'(n_pop), 128'(p0));

        // random traffic with random bubbles and backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [127:0] d;
            logic [6:0]   a;
            mode_e        md;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            d  = {$urandom, $urandom, $urandom, $urandom};
            a  = (i % 10 == 0) ? 7'd127 : (i % 10 == 1) ? 7'd0 : 7'($urandom_range(0, 127));
            md = mode_e'($urandom_range(0, 3));
            m  = model(d, a, md);
            send(d, a, md, 8'(i), m[127:0], m[128]);
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();
        check("total_pops", 128'(n_pop), 128'(n_push));

        // 8-bit instance, LPS=1
        for (int i = 0; i < 11; i++) run8(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
